pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/forwarding controller for the in-order core, replacing the hazard-free pipeline.
//  Shadows in-flight instructions in a DEPTH-entry scoreboard (EX..WB).
//  From the scoreboard it generates the PC/IF-ID stall, the IF-ID flush, the ID-EX bubble
//  and registered EX-operand forward selects.
//  Load-use stalls, taken-branch flush and a global hold (multi-cycle memory).
// PARAMETERS
//  REG_AW      5  register address width
//  DEPTH       3  scoreboard stages after ID (1=EX, 2=MEM, ..., DEPTH=WB); >=2
//  LOAD_READY  3  first stage index whose load result is forwardable; 2..DEPTH
//  ZERO_REG    1  1: address 0 never matches (hardwired zero); 0: r0 is a normal register
//  CNT_W       16 performance counter width
//  (localparam FSW = $clog2(DEPTH+1))
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      asynchronous active-low reset
//  hold             in   1      global freeze (memory wait)
//  id_valid         in   1      ID holds a real instruction
//  id_rs_a          in   REG_AW ID source A (rn)
//  id_rs_b          in   REG_AW ID source B (rm)
//  id_use_a         in   1      ID reads source A
//  id_use_b         in   1      ID reads source B
//  id_rd            in   REG_AW ID destination
//  id_reg_write     in   1      ID writes id_rd
//  id_is_load       in   1      ID is a RAM load
//  ex_branch_taken  in   1      instruction in EX redirects the PC this cycle
//  stall_pc         out  1      hold PC (comb)
//  stall_if_id      out  1      hold IF/ID register (comb)
//  flush_if_id      out  1      clear IF/ID register (comb)
//  bubble_id_ex     out  1      load NOP into ID/EX (comb)
//  fwd_sel_a        out  FSW    EX operand A: 0=RD1, k=result of stage k (registered)
//  fwd_sel_b        out  FSW    EX operand B; same encoding (registered)
//  stall_count      out  CNT_W  load-use stall cycles, saturating
//  flush_count      out  CNT_W  branch flushes, saturating
// BEHAVIOUR
//  Scoreboard entry: valid, rd, reg_write, is_load. match(k,r): sb[k].valid & reg_write
//    & sb[k].rd==r & !(ZERO_REG & r==0), for k in 1..DEPTH-1. sb[DEPTH] is never matched;
//    the register file is write-through.
//  Youngest (lowest k) match wins per operand; unused operand (id_use_x=0) never matches.
//  lu = id_valid & an operand's youngest match is a load with k+1 < LOAD_READY.
//  br = ex_branch_taken & sb[1].valid.
//  Priority: hold > br > lu.
//    hold: stall_pc=stall_if_id=1, flush=bubble=0; scoreboard, fwd_sel, counters frozen.
//      The branch source keeps ex_branch_taken high across hold.
//    br: flush_if_id=1, bubble_id_ex=1, stall=0; sb[1]<=bubble; flush_count+1.
//    lu: stall_pc=stall_if_id=bubble_id_ex=1; sb[1]<=bubble; stall_count+1.
//    else: all 0. sb[1]<=ID instruction (valid=id_valid).
//  Shift: sb[k]<=sb[k-1] for k>=2 every non-hold cycle, including stall and flush.
//  fwd_sel_x <= (youngest match k) ? k+1 : 0 when ID issues, else 0; same edge as ID/EX.
//    Registered latency 1: valid while that instruction is in EX.
//  Counters saturate at 2^CNT_W-1 (no wrap).
//  Reset (rst=0, async): all sb.valid=0, fwd_sel=0, counters=0.
//    Comb outputs 0 during reset unless hold=1.
//  Mid-operation reset discards in-flight entries; first post-reset issue sees no hazards.
// TESTING
//  1. Reset mid-run with 3 valid entries -> all outputs 0, next ALU issue fwd_sel=0.
//  2. ADD r3 then SUB r4,r3,r5 back-to-back -> fwd_sel_a=2 (MEM) on SUB's EX cycle.
//     Gap of one -> fwd_sel_a=3; gap of two -> 0.
//  3. LOAD r7 then ADD r8,r7,r1 -> one cycle stall_pc/stall_if_id/bubble_id_ex.
//     Then fwd_sel_a=3; stall_count=1.
//  4. Branch taken in EX while ID reads a stale hazard -> flush_if_id=1, stall=0.
//     flush_count=1; no stall_count increment.
//  5. hold=1 for 4 cycles mid-hazard -> scoreboard/fwd_sel/counters unchanged, stall_pc=1.
//     Resumes identically after release.
//  6. rd=0 writer then r0 reader with ZERO_REG=1 -> fwd_sel=0.
//     CNT_W=2 with 5 load-use stalls -> stall_count=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage instruction fields, branch/hold inputs and the hazard-control outputs
// exchanged between the in-order core and its hazard/forwarding controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int FSW = $clog2(DEPTH + 1);

  logic              hold;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_a;
  logic [REG_AW-1:0] id_rs_b;
  logic              id_use_a;
  logic              id_use_b;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_is_load;
  logic              ex_branch_taken;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              bubble_id_ex;
  logic [FSW-1:0]    fwd_sel_a;
  logic [FSW-1:0]    fwd_sel_b;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output hold, id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
           id_rd, id_reg_write, id_is_load, ex_branch_taken,
    input  stall_pc, stall_if_id, flush_if_id, bubble_id_ex,
           fwd_sel_a, fwd_sel_b, stall_count, flush_count
  );

  modport slave (
    input  hold, id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
           id_rd, id_reg_write, id_is_load, ex_branch_taken,
    output stall_pc, stall_if_id, flush_if_id, bubble_id_ex,
           fwd_sel_a, fwd_sel_b, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: shadows EX..WB in a scoreboard and derives stalls,
// flushes, bubbles and registered EX operand forward selects from it.
module pipeline_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int FSW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } sb_entry_t;

  sb_entry_t        sb_q [1:DEPTH];
  sb_entry_t        sb_d [1:DEPTH];
  logic [FSW-1:0]   fwd_a_q, fwd_a_d;
  logic [FSW-1:0]   fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_a, hit_b, load_a, load_b;
  int   k_a, k_b;
  logic lu, br;

  function automatic logic entry_match(input sb_entry_t e, input logic [REG_AW-1:0] r,
                                       input logic use_r);
    return use_r && e.valid && e.reg_write && (e.rd == r) &&
           !((ZERO_REG != 0) && (r == {REG_AW{1'b0}}));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Youngest producer per operand; the loop runs oldest-first so the lowest stage wins.
  always_comb begin
    hit_a  = 1'b0;
    load_a = 1'b0;
    k_a    = 0;
    hit_b  = 1'b0;
    load_b = 1'b0;
    k_b    = 0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (hz.id_valid && entry_match(sb_q[k], hz.id_rs_a, hz.id_use_a)) begin
        hit_a  = 1'b1;
        load_a = sb_q[k].is_load;
        k_a    = k;
      end else begin
        hit_a  = hit_a;
      end
      if (hz.id_valid && entry_match(sb_q[k], hz.id_rs_b, hz.id_use_b)) begin
        hit_b  = 1'b1;
        load_b = sb_q[k].is_load;
        k_b    = k;
      end else begin
        hit_b  = hit_b;
      end
    end
    lu = (hit_a && load_a && (k_a + 1 < LOAD_READY)) ||
         (hit_b && load_b && (k_b + 1 < LOAD_READY));
    br = hz.ex_branch_taken && sb_q[1].valid;
  end

  // Pipeline control strobes; hold dominates, then branch flush, then load-use stall.
  always_comb begin
    hz.stall_pc     = hz.hold || (!br && lu);
    hz.stall_if_id  = hz.hold || (!br && lu);
    hz.flush_if_id  = !hz.hold && br;
    hz.bubble_id_ex = !hz.hold && (br || lu);
  end

  // Next scoreboard, forward selects and counters.
  always_comb begin
    sb_d        = sb_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hz.hold) begin
      for (int k = 2; k <= DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      if (br) begin
        sb_d[1]     = '0;
        fwd_a_d     = {FSW{1'b0}};
        fwd_b_d     = {FSW{1'b0}};
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (lu) begin
        sb_d[1]     = '0;
        fwd_a_d     = {FSW{1'b0}};
        fwd_b_d     = {FSW{1'b0}};
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        sb_d[1].valid     = hz.id_valid;
        sb_d[1].rd        = hz.id_rd;
        sb_d[1].reg_write = hz.id_reg_write;
        sb_d[1].is_load   = hz.id_is_load;
        fwd_a_d = hit_a ? FSW'(k_a + 1) : {FSW{1'b0}};
        fwd_b_d = hit_b ? FSW'(k_b + 1) : {FSW{1'b0}};
      end
    end else begin
      sb_d = sb_q;
    end
  end

  // State registers; reset discards every in-flight entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      fwd_a_q     <= {FSW{1'b0}};
      fwd_b_q     <= {FSW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sb_q        <= sb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.fwd_sel_a   = fwd_a_q;
  assign hz.fwd_sel_b   = fwd_b_q;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed trace-table bench for pipeline_hazard_ctrl plus hand-written hold, reset,
// branch-under-hold and counter-saturation sequences.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) m_if ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3), .CNT_W(2))  s_if ();

  pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_READY(3), .ZERO_REG(1), .CNT_W(16))
    u_dut (.clk(clk), .rst(rst), .hz(m_if));
  pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_READY(3), .ZERO_REG(1), .CNT_W(2))
    u_sat (.clk(clk), .rst(rst), .hz(s_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       hold, v;
    logic [4:0] ra, rb;
    logic       ua, ub;
    logic [4:0] rd;
    logic       rw, ld, br;
    logic       spc, sif, fl, bub;
    int         fa, fb, sc, fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic hold, v, input int ra, rb, input logic ua, ub,
                              input int rd, input logic rw, ld, br,
                              input logic spc, sif, fl, bub, input int fa, fb, sc, fc);
    vec_t r;
    r.hold = hold; r.v = v; r.ra = 5'(ra); r.rb = 5'(rb); r.ua = ua; r.ub = ub;
    r.rd = 5'(rd); r.rw = rw; r.ld = ld; r.br = br;
    r.spc = spc; r.sif = sif; r.fl = fl; r.bub = bub;
    r.fa = fa; r.fb = fb; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic hold, v, input int ra, rb, input logic ua, ub,
                       input int rd, input logic rw, ld, br);
    m_if.hold = hold; m_if.id_valid = v; m_if.id_rs_a = 5'(ra); m_if.id_rs_b = 5'(rb);
    m_if.id_use_a = ua; m_if.id_use_b = ub; m_if.id_rd = 5'(rd);
    m_if.id_reg_write = rw; m_if.id_is_load = ld; m_if.ex_branch_taken = br;
  endtask

  task automatic sdrive(input logic v, input int ra, rb, input logic ua, ub,
                        input int rd, input logic rw, ld);
    s_if.hold = 1'b0; s_if.id_valid = v; s_if.id_rs_a = 5'(ra); s_if.id_rs_b = 5'(rb);
    s_if.id_use_a = ua; s_if.id_use_b = ub; s_if.id_rd = 5'(rd);
    s_if.id_reg_write = rw; s_if.id_is_load = ld; s_if.ex_branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input int spc, sif, fl, bub);
    chk({tag, " stall_pc"},     int'(m_if.stall_pc),     spc);
    chk({tag, " stall_if_id"},  int'(m_if.stall_if_id),  sif);
    chk({tag, " flush_if_id"},  int'(m_if.flush_if_id),  fl);
    chk({tag, " bubble_id_ex"}, int'(m_if.bubble_id_ex), bub);
  endtask

  task automatic chk_reg(input string tag, input int fa, fb, sc, fc);
    chk({tag, " fwd_sel_a"},   int'(m_if.fwd_sel_a),   fa);
    chk({tag, " fwd_sel_b"},   int'(m_if.fwd_sel_b),   fb);
    chk({tag, " stall_count"}, int'(m_if.stall_count), sc);
    chk({tag, " flush_count"}, int'(m_if.flush_count), fc);
  endtask

  initial begin
    //           hold v  ra  rb ua ub rd rw ld br | spc sif fl bub | fa fb sc fc
    vecs.push_back(mk(0,1, 1, 2,1,1, 3,1,0,0, 0,0,0,0, 0,0,0,0)); // ADD r3
    vecs.push_back(mk(0,1, 3, 5,1,1, 4,1,0,0, 0,0,0,0, 0,0,0,0)); // SUB r4,r3,r5
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 2,0,0,0)); // SUB in EX: MEM fwd
    vecs.push_back(mk(0,1, 1, 2,1,1,10,1,0,0, 0,0,0,0, 0,0,0,0)); // ADD r10
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,10, 4,1,1,11,1,0,0, 0,0,0,0, 0,0,0,0)); // gap of one
    vecs.push_back(mk(0,1, 1, 2,1,1,12,1,0,0, 0,0,0,0, 3,0,0,0)); // WB fwd visible
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,12,11,1,1,13,1,0,0, 0,0,0,0, 0,0,0,0)); // gap of two
    vecs.push_back(mk(0,1, 1, 0,1,0, 7,1,1,0, 0,0,0,0, 0,0,0,0)); // LOAD r7
    vecs.push_back(mk(0,1, 7, 1,1,1, 8,1,0,0, 1,1,0,1, 0,0,0,0)); // load-use stall
    vecs.push_back(mk(0,1, 7, 1,1,1, 8,1,0,0, 0,0,0,0, 0,0,1,0)); // re-issue
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 3,0,1,0));
    vecs.push_back(mk(0,1, 1, 8,1,1, 9,1,0,0, 0,0,0,0, 0,0,1,0)); // operand B WB fwd
    vecs.push_back(mk(0,1, 9, 9,1,1, 2,1,0,0, 0,0,0,0, 0,3,1,0)); // both operands
    vecs.push_back(mk(0,1, 1, 0,1,0, 5,1,1,0, 0,0,0,0, 2,2,1,0)); // LOAD r5
    vecs.push_back(mk(0,1, 5, 1,1,1, 6,1,0,1, 0,0,1,1, 0,0,1,0)); // branch beats lu
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,1, 1, 2,1,1, 0,1,0,0, 0,0,0,0, 0,0,1,1)); // writer of r0
    vecs.push_back(mk(0,1, 0, 0,1,1, 4,1,0,0, 0,0,0,0, 0,0,1,1)); // reader of r0
    vecs.push_back(mk(0,1, 1, 2,1,1, 3,1,0,0, 0,0,0,0, 0,0,1,1)); // r0 -> no fwd
    vecs.push_back(mk(0,1, 3, 4,0,1, 5,1,0,0, 0,0,0,0, 0,0,1,1)); // unused A
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,3,1,1));
    vecs.push_back(mk(0,0, 5, 5,1,1, 0,0,0,0, 0,0,0,0, 0,0,1,1)); // invalid ID
    vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1,1));

    rst = 1'b0;
    drive(0,0,0,0,0,0,0,0,0,0);
    sdrive(0,0,0,0,0,0,0,0);
    #12;
    chk_ctl("reset", 0, 0, 0, 0);
    chk_reg("reset", 0, 0, 0, 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].hold, vecs[i].v, vecs[i].ra, vecs[i].rb, vecs[i].ua, vecs[i].ub,
            vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].br);
      #1;
      chk_ctl($sformatf("row%0d", i), vecs[i].spc, vecs[i].sif, vecs[i].fl, vecs[i].bub);
      chk_reg($sformatf("row%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].sc, vecs[i].fc);
      tick();
    end

    // Hold for four cycles in the middle of a load-use hazard.
    drive(0,1, 1, 2,1,1,20,1,0,0); tick();
    drive(0,1,20, 0,1,0,21,1,1,0); tick();
    for (int c = 0; c < 4; c++) begin
      drive(1,1,21, 1,1,1,22,1,0,0);
      #1;
      chk_ctl($sformatf("hold%0d", c), 1, 1, 0, 0);
      chk_reg($sformatf("hold%0d", c), 2, 0, 1, 1);
      tick();
    end
    drive(0,1,21, 1,1,1,22,1,0,0);
    #1;
    chk_ctl("hold_release", 1, 1, 0, 1);
    chk_reg("hold_release", 2, 0, 1, 1);
    tick();
    chk_ctl("after_stall", 0, 0, 0, 0);
    chk_reg("after_stall", 0, 0, 2, 1);
    tick();
    chk("resume fwd_sel_a", int'(m_if.fwd_sel_a), 3);

    // Asynchronous reset with three valid in-flight entries and a pending load-use.
    drive(0,1, 1, 2,1,1,23,1,0,0); tick();
    drive(0,1, 1, 2,1,1,24,1,0,0); tick();
    drive(0,1,24, 0,1,0,25,1,1,0); tick();
    drive(0,1,25,24,1,1,26,1,0,0);
    #1;
    chk("pre_reset stall_pc", int'(m_if.stall_pc), 1);
    chk("pre_reset fwd_sel_a", int'(m_if.fwd_sel_a), 2);
    rst = 1'b0;
    #1;
    chk_ctl("mid_reset", 0, 0, 0, 0);
    chk_reg("mid_reset", 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_ctl("post_reset", 0, 0, 0, 0);
    tick();
    chk_reg("first_issue", 0, 0, 0, 0);

    // Taken branch held off by hold: no flush until hold drops.
    drive(1,0, 0, 0,0,0, 0,0,0,1);
    #1;
    chk_ctl("br_hold", 1, 1, 0, 0);
    tick();
    chk("br_hold flush_count", int'(m_if.flush_count), 0);
    drive(0,0, 0, 0,0,0, 0,0,0,1);
    #1;
    chk_ctl("br_release", 0, 0, 1, 1);
    tick();
    drive(0,0, 0, 0,0,0, 0,0,0,0);
    chk("br_release flush_count", int'(m_if.flush_count), 1);
    chk("br_release stall_count", int'(m_if.stall_count), 0);

    // Five load-use stalls on a 2-bit counter: saturates at 3.
    for (int n = 0; n < 5; n++) begin
      sdrive(1, 1, 0,1,0, 7,1,1); tick();
      sdrive(1, 7, 1,1,1, 8,1,0);
      #1;
      chk($sformatf("sat%0d stall_pc", n), int'(s_if.stall_pc), 1);
      tick();
      tick();
      sdrive(0, 0, 0,0,0, 0,0,0); tick();
      if (n == 1) begin
        chk("sat mid stall_count", int'(s_if.stall_count), 2);
      end else begin
        chk($sformatf("sat%0d flush_count", n), int'(s_if.flush_count), 0);
      end
    end
    chk("sat stall_count", int'(s_if.stall_count), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
